// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target controller and its FIFOs.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

  typedef enum bit {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  localparam int I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_target_fifo.sv
// Synchronous FIFO with valid/ready on both sides; DEPTH must be a power of two.
module i2c_target_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign wready_o = (count_q != (AW+1)'(DEPTH));
  assign rvalid_o = (count_q != '0);
  assign push     = wvalid_i & wready_o;
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = mem_q[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target controller: oversampled SCL/SDA, START/STOP decode, 7-bit address
// match, write bytes into an RX FIFO and read bytes served from a TX FIFO.
module i2c_target_ctrl
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR    = 7'h22,
  parameter int         FIFO_DEPTH     = 16,
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] UNDERFLOW_BYTE = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       op_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       rx_overflow_o,
  output logic       tx_underflow_o,
  input  logic       clr_status_i
);

  localparam logic [3:0] BYTE_FULL = 4'(I2C_BYTE_BITS);
  localparam logic [3:0] BYTE_LAST = 4'(I2C_BYTE_BITS - 1);

  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic                   sclPrev_q, sdaPrev_q;
  logic                   sclS, sdaS;
  logic                   sclRise, sclFall, startCond, stopCond;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  i2c_op_t        op_q, op_d;
  logic           sdaOe_q, sdaOe_d;
  logic           start_q, start_d, stop_q, stop_d;
  logic           rxOvf_q, rxOvf_d, txUnf_q, txUnf_d;

  logic       rxPush, rxNotFull, txPop, txAvail, ovfSet, unfSet, loadRd;
  logic [7:0] txHead, nextByte;

  assign sclS      = sclSync_q[SYNC_STAGES-1];
  assign sdaS      = sdaSync_q[SYNC_STAGES-1];
  assign sclRise   = sclS & ~sclPrev_q;
  assign sclFall   = ~sclS & sclPrev_q;
  assign startCond = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
  assign stopCond  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
      sclPrev_q <= sclS;
      sdaPrev_q <= sdaS;
    end
  end

  // Bus conditions override bit handling; ADDR and WR_DATA share the shift-in path.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    op_d     = op_q;
    sdaOe_d  = sdaOe_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    rxPush   = 1'b0;
    txPop    = 1'b0;
    ovfSet   = 1'b0;
    unfSet   = 1'b0;
    loadRd   = 1'b0;
    nextByte = txAvail ? txHead : UNDERFLOW_BYTE;
    if (startCond) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
      start_d  = 1'b1;
    end else if (stopCond) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      stop_d  = 1'b1;
    end else begin
      unique case (state_q)
        ADDR, WR_DATA: begin
          if (sclRise && bitCnt_q != BYTE_FULL) begin
            shift_d  = {shift_q[6:0], sdaS};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == BYTE_FULL) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                op_d    = i2c_op_t'(shift_q[0]);
                sdaOe_d = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else if (rxNotFull) begin
              rxPush  = 1'b1;
              sdaOe_d = 1'b1;
              state_d = WR_ACK;
            end else begin
              ovfSet  = 1'b1;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (sclFall) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = '0;
            if (op_q == I2C_READ) loadRd = 1'b1;
            else                  state_d = WR_DATA;
          end
        end
        WR_ACK: begin
          if (sclFall) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = '0;
            state_d  = WR_DATA;
          end
        end
        RD_DATA: begin
          if (sclFall) begin
            if (bitCnt_q == BYTE_LAST) begin
              sdaOe_d = 1'b0;
              state_d = RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sdaOe_d  = ~shift_q[6];
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (sclRise && sdaS) state_d = IGNORE;
          else if (sclFall)    loadRd  = 1'b1;
        end
        IDLE, IGNORE: sdaOe_d = 1'b0;
        default:      state_d = IDLE;
      endcase
      if (loadRd) begin
        txPop    = txAvail;
        unfSet   = ~txAvail;
        shift_d  = nextByte;
        sdaOe_d  = ~nextByte[7];
        bitCnt_d = '0;
        state_d  = RD_DATA;
      end
    end
  end

  // A set event in the same cycle as clr_status_i wins.
  assign rxOvf_d = ovfSet | (rxOvf_q & ~clr_status_i);
  assign txUnf_d = unfSet | (txUnf_q & ~clr_status_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      op_q     <= I2C_WRITE;
      sdaOe_q  <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      rxOvf_q  <= 1'b0;
      txUnf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      op_q     <= op_d;
      sdaOe_q  <= sdaOe_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      rxOvf_q  <= rxOvf_d;
      txUnf_q  <= txUnf_d;
    end
  end

  i2c_target_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(I2C_BYTE_BITS)) uRxFifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wdata_i  (shift_q),
    .wvalid_i (rxPush),
    .wready_o (rxNotFull),
    .rdata_o  (rx_data_o),
    .rvalid_o (rx_valid_o),
    .rready_i (rx_ready_i)
  );

  i2c_target_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(I2C_BYTE_BITS)) uTxFifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wdata_i  (tx_data_i),
    .wvalid_i (tx_valid_i),
    .wready_o (tx_ready_o),
    .rdata_o  (txHead),
    .rvalid_o (txAvail),
    .rready_i (txPop)
  );

  assign sda_oe_o       = sdaOe_q;
  assign busy_o         = (state_q != IDLE) && (state_q != IGNORE);
  assign op_o           = op_q;
  assign start_o        = start_q;
  assign stop_o         = stop_q;
  assign rx_overflow_o  = rxOvf_q;
  assign tx_underflow_o = txUnf_q;

endmodule
